uart_apb_echo_master: RTL and testbench

- APB3 master sitting directly upstream of the uart_apb slave. Replaces the tied-off in_* bus in the tile top.
- After reset it programs the UART baud divisor and control register, then runs forever as a byte-echo engine. It polls status, reads each received byte, waits for TX free and writes the byte back.
- Gives the tile a self-contained UART loopback exercised through the real APB path.

---
 rtl/uart_apb_echo_master.sv | 118 +++++++++++
 tb/tb_uart_apb_echo_master.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_apb_echo_master.sv
// uart_apb_echo_master: APB3 master that sets up the UART, then echoes every received byte back to it.
// Defining UART_APB_ECHO_TIMEOUT_EN adds an ACCESS-phase timeout that aborts the transfer and retries it.
module uart_apb_echo_master #(
  parameter logic [15:0] BAUD_DIV  = 16'd104,
  parameter logic [31:0] CTRL_INIT = 32'h0000_0003,
  parameter logic [31:0] DIV_ADDR  = 32'h0000_0000,
  parameter logic [31:0] DATA_ADDR = 32'h0000_0004,
  parameter logic [31:0] STAT_ADDR = 32'h0000_0008,
  parameter logic [31:0] CTRL_ADDR = 32'h0000_000C
`ifdef UART_APB_ECHO_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  output logic        out_psel,
  output logic        out_penable,
  output logic [2:0]  out_pprot,
  output logic [31:0] out_paddr,
  output logic        out_pwrite,
  output logic [31:0] out_pwdata,
  output logic [3:0]  out_pstrb,
  input  logic        in_pready,
  input  logic        in_pslverr,
  input  logic [31:0] in_prdata,
  output logic        init_done,
  output logic        err,
  output logic [7:0]  echo_count,
  output logic [7:0]  last_byte
);
  localparam logic [2:0] S_DIV     = 3'd0;
  localparam logic [2:0] S_CTRL    = 3'd1;
  localparam logic [2:0] S_POLL_RX = 3'd2;
  localparam logic [2:0] S_READ    = 3'd3;
  localparam logic [2:0] S_POLL_TX = 3'd4;
  localparam logic [2:0] S_WRITE   = 3'd5;
  logic [2:0]  r_state;
  logic [7:0]  r_byte;
  logic [2:0]  w_next;
  logic        w_poll;
  logic        w_write;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_unused;
`ifdef UART_APB_ECHO_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] r_tmo;
`endif
  assign out_pprot = 3'b000;
  assign w_unused  = ^in_prdata[31:8];
  assign w_poll    = r_state == S_POLL_RX || r_state == S_POLL_TX;
  assign w_write   = r_state == S_DIV || r_state == S_CTRL || r_state == S_WRITE;
  assign w_addr    = r_state == S_DIV  ? DIV_ADDR :
                     r_state == S_CTRL ? CTRL_ADDR :
                     w_poll            ? STAT_ADDR : DATA_ADDR;
  assign w_wdata   = r_state == S_DIV  ? {16'b0, BAUD_DIV} :
                     r_state == S_CTRL ? CTRL_INIT : {24'b0, r_byte};
  // An errored poll counts as "not ready" so the poll repeats
  assign w_next    = r_state == S_DIV     ? S_CTRL :
                     r_state == S_POLL_RX ? (in_prdata[0] && !in_pslverr ? S_READ : S_POLL_RX) :
                     r_state == S_READ    ? S_POLL_TX :
                     r_state == S_POLL_TX ? (!in_prdata[1] && !in_pslverr ? S_WRITE : S_POLL_TX) :
                     S_POLL_RX;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_psel    <= 1'b0;
      out_penable <= 1'b0;
      out_paddr   <= '0;
      out_pwrite  <= 1'b0;
      out_pwdata  <= '0;
      out_pstrb   <= '0;
      init_done   <= 1'b0;
      err         <= 1'b0;
      echo_count  <= '0;
      last_byte   <= '0;
      r_state     <= S_DIV;
      r_byte      <= '0;
`ifdef UART_APB_ECHO_TIMEOUT_EN
      r_tmo       <= '0;
`endif
    end else if (!out_psel) begin
      if (enable) begin
        out_psel   <= 1'b1;
        out_paddr  <= w_addr;
        out_pwrite <= w_write;
        out_pwdata <= w_wdata;
        out_pstrb  <= {4{w_write}};
      end
    end else if (!out_penable) begin
      out_penable <= 1'b1;
`ifdef UART_APB_ECHO_TIMEOUT_EN
      r_tmo       <= '0;
`endif
    end else if (in_pready) begin
      out_psel    <= 1'b0;
      out_penable <= 1'b0;
      out_pstrb   <= '0;
      r_state     <= w_next;
      if (in_pslverr) err <= 1'b1;
      if (r_state == S_CTRL) init_done <= 1'b1;
      if (r_state == S_READ) r_byte <= in_prdata[7:0];
      if (r_state == S_WRITE) begin
        last_byte  <= r_byte;
        echo_count <= echo_count + 8'd1;
      end
    end
`ifdef UART_APB_ECHO_TIMEOUT_EN
    else if (r_tmo == TMO_LAST) begin
      out_psel    <= 1'b0;
      out_penable <= 1'b0;
      out_pstrb   <= '0;
      err         <= 1'b1;
    end else r_tmo <= r_tmo + 1'b1;
`endif
  end
endmodule

// File: tb/tb_uart_apb_echo_master.sv
// tb_uart_apb_echo_master: scoreboard bench; an APB slave model pops the expected transfer
// at every SETUP, checks it, and answers with the queued read data / error / wait states.
module tb_uart_apb_echo_master;
  logic        clk = 1'b0, resetn = 1'b0, enable = 1'b0;
  logic        out_psel, out_penable, out_pwrite;
  logic [2:0]  out_pprot;
  logic [31:0] out_paddr, out_pwdata;
  logic [3:0]  out_pstrb;
  logic        in_pready = 1'b0, in_pslverr = 1'b0;
  logic [31:0] in_prdata = '0;
  logic        init_done, err;
  logic [7:0]  echo_count, last_byte;
  int n_tests = 0, n_fail = 0;
  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        slverr;
    int          wait_n;
    int          exp_acc;
    logic        is_auto;
  } txn_t;
  txn_t q[$];
  txn_t cur;
  logic busy = 1'b0;
  int   acc = 0;
  localparam logic [31:0] DIV = 32'h0, DATA = 32'h4, STAT = 32'h8, CTRL = 32'hC;
  always #5 clk = ~clk;
  uart_apb_echo_master dut (
    .clk(clk), .resetn(resetn), .enable(enable),
    .out_psel(out_psel), .out_penable(out_penable), .out_pprot(out_pprot),
    .out_paddr(out_paddr), .out_pwrite(out_pwrite), .out_pwdata(out_pwdata),
    .out_pstrb(out_pstrb), .in_pready(in_pready), .in_pslverr(in_pslverr),
    .in_prdata(in_prdata), .init_done(init_done), .err(err),
    .echo_count(echo_count), .last_byte(last_byte)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic push(input logic [31:0] a, input logic w, input logic [31:0] wd,
                      input logic [31:0] rd, input logic se, input int wn, input int ea);
    q.push_back('{a, w, wd, rd, se, wn, ea, 1'b0});
  endtask
  task automatic poll(input logic [31:0] rd, input logic se);
    push(STAT, 1'b0, 32'h0, rd, se, 0, 1);
  endtask
  task automatic echo(input logic [7:0] b, input logic rd_err);
    poll(32'h1, 1'b0);
    push(DATA, 1'b0, 32'h0, {24'hABCDEF, b}, rd_err, 0, 1);
    poll(32'hFFFF_FFFD, 1'b0);
    push(DATA, 1'b1, {24'b0, b}, 32'h0, 1'b0, 0, 1);
  endtask
  task automatic push_init(input logic ctrl_err);
    push(DIV, 1'b1, 32'd104, 32'h0, 1'b0, 0, 1);
    push(CTRL, 1'b1, 32'h3, 32'h0, ctrl_err, 0, 1);
  endtask
  task automatic drain(input string tag, input int budget);
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while ((q.size() != 0 || busy) && n < budget);
    check({tag, "_drain"}, 32'(q.size() == 0 && !busy), 32'd1);
    q.delete();
    @(negedge clk);
    enable = 1'b0;
    repeat (5) @(negedge clk);
  endtask
  // Slave model: all decisions made on the falling edge, away from the DUT's active edge
  always @(negedge clk) begin
    if (!out_psel) begin
      if (busy && cur.exp_acc != 0) check("acc_len", 32'(acc), 32'(cur.exp_acc));
      busy = 1'b0;
      in_pready = 1'b0;
      in_pslverr = 1'b0;
    end else if (!out_penable) begin
      if (q.size() != 0) begin
        cur = q.pop_front();
        check("setup_addr", out_paddr, cur.addr);
        check("setup_write", 32'(out_pwrite), 32'(cur.wr));
        check("setup_strb", 32'(out_pstrb), cur.wr ? 32'hF : 32'h0);
        if (cur.wr) check("setup_wdata", out_pwdata, cur.wdata);
      end else cur = '{32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 0, 0, 1'b1};
      busy = 1'b1;
      acc = 0;
      in_pready = 1'b0;
    end else begin
      acc++;
      if (!cur.is_auto) begin
        check("acc_addr", out_paddr, cur.addr);
        check("acc_strb", 32'(out_pstrb), cur.wr ? 32'hF : 32'h0);
      end
      in_pready  = acc > cur.wait_n;
      in_prdata  = acc > cur.wait_n ? cur.rdata : 32'hEEEE_EEEE;
      in_pslverr = acc > cur.wait_n ? cur.slverr : 1'b0;
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    logic [7:0] b;
    logic [7:0] last_b;
    int n;
    // Reset values and exact first-transfer timing
    repeat (3) @(negedge clk);
    check("rst_psel", 32'(out_psel), 32'd0);
    check("rst_penable", 32'(out_penable), 32'd0);
    check("rst_pstrb", 32'(out_pstrb), 32'd0);
    check("rst_pprot", 32'(out_pprot), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_echo_count", 32'(echo_count), 32'd0);
    check("rst_last_byte", 32'(last_byte), 32'd0);
    push_init(1'b0);
    resetn = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    check("c1_setup", 32'({out_psel, out_penable}), 32'b10);
    @(negedge clk);
    check("c2_access", 32'({out_psel, out_penable}), 32'b11);
    @(negedge clk);
    check("c3_idle", 32'({out_psel, out_penable}), 32'b00);
    check("init_not_yet", 32'(init_done), 32'd0);
    drain("init", 100);
    check("init_done", 32'(init_done), 32'd1);
    check("init_err", 32'(err), 32'd0);
    // Three empty polls, one byte, TX busy once
    repeat (3) poll(32'h0, 1'b0);
    poll(32'h1, 1'b0);
    push(DATA, 1'b0, 32'h0, 32'h41, 1'b0, 0, 1);
    poll(32'h2, 1'b0);
    poll(32'h0, 1'b0);
    push(DATA, 1'b1, 32'h41, 32'h0, 1'b0, 0, 1);
    enable = 1'b1;
    drain("echo41", 200);
    check("echo41_last", 32'(last_byte), 32'h41);
    check("echo41_count", 32'(echo_count), 32'd1);
    // Wait states on the DATA read
    poll(32'h1, 1'b0);
    push(DATA, 1'b0, 32'h0, 32'h5A, 1'b0, 5, 6);
    poll(32'h0, 1'b0);
    push(DATA, 1'b1, 32'h5A, 32'h0, 1'b0, 0, 1);
    enable = 1'b1;
    drain("wait", 200);
    check("wait_last", 32'(last_byte), 32'h5A);
    check("wait_count", 32'(echo_count), 32'd2);
    // Error on CTRL, then 256 echoes with errored poll/read mixed in
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    check("rst2_count", 32'(echo_count), 32'd0);
    check("rst2_init", 32'(init_done), 32'd0);
    push_init(1'b1);
    resetn = 1'b1;
    enable = 1'b1;
    drain("ctrl_err", 100);
    check("ctrl_err_err", 32'(err), 32'd1);
    check("ctrl_err_init", 32'(init_done), 32'd1);
    last_b = 8'h0;
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom_range(0, 255));
      if (i == 0) poll(32'h1, 1'b1);
      if (i == 2) begin
        poll(32'h1, 1'b0);
        push(DATA, 1'b0, 32'h0, {24'h0, b}, 1'b0, 0, 1);
        poll(32'h0, 1'b1);
        poll(32'h0, 1'b0);
        push(DATA, 1'b1, {24'b0, b}, 32'h0, 1'b0, 0, 1);
      end else echo(b, i == 1);
      last_b = b;
    end
    enable = 1'b1;
    drain("wrap", 8000);
    check("wrap_count", 32'(echo_count), 32'd0);
    check("wrap_last", 32'(last_byte), 32'(last_b));
    check("wrap_err", 32'(err), 32'd1);
    // Reset during ACCESS of the echo write
    echo(8'h33, 1'b0);
    poll(32'h1, 1'b0);
    push(DATA, 1'b0, 32'h0, 32'h77, 1'b0, 0, 1);
    poll(32'h0, 1'b0);
    push(DATA, 1'b1, 32'h77, 32'h0, 1'b0, 10, 0);
    enable = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(out_psel && out_penable && out_pwrite && out_paddr == DATA && echo_count == 8'd1) && n < 200);
    check("rstw_found", 32'(n < 200), 32'd1);
    check("rstw_pre_last", 32'(last_byte), 32'h33);
    resetn = 1'b0;
    @(negedge clk);
    check("rstw_psel", 32'({out_psel, out_penable}), 32'd0);
    check("rstw_count", 32'(echo_count), 32'd0);
    check("rstw_last", 32'(last_byte), 32'd0);
    check("rstw_err", 32'(err), 32'd0);
    check("rstw_q_empty", 32'(q.size()), 32'd0);
    q.delete();
    push_init(1'b0);
    resetn = 1'b1;
    enable = 1'b1;
    drain("restart", 100);
    check("restart_init", 32'(init_done), 32'd1);
`ifdef UART_APB_ECHO_TIMEOUT_EN
    push(STAT, 1'b0, 32'h0, 32'h0, 1'b0, 100000, 16);
    poll(32'h0, 1'b0);
    enable = 1'b1;
    drain("timeout", 200);
    check("timeout_err", 32'(err), 32'd1);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
